// File: rtl/ctrl_pipe_sequencer_if.sv
// ID-stage control inputs and EX/MEM/WB control outputs of the pipeline sequencer.
// The master side drives the ID/branch inputs; the sequencer is the slave.
interface ctrl_pipe_sequencer_if;
    logic        halt;
    logic        id_valid;
    logic [8:0]  id_execute_bus;
    logic [2:0]  id_memory_bus;
    logic [1:0]  id_wb_bus;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        branch_taken;

    logic [8:0]  ex_execute_bus;
    logic [2:0]  ex_memory_bus;
    logic [1:0]  ex_wb_bus;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_write_reg;
    logic [2:0]  mem_memory_bus;
    logic [1:0]  mem_wb_bus;
    logic [4:0]  mem_write_reg;
    logic [1:0]  wb_wb_bus;
    logic [4:0]  wb_write_reg;
    logic        stall;
    logic        flush_if_id;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output halt, id_valid, id_execute_bus, id_memory_bus, id_wb_bus,
               id_rs, id_rt, id_rd, branch_taken,
        input  ex_execute_bus, ex_memory_bus, ex_wb_bus, ex_rs, ex_rt, ex_write_reg,
               mem_memory_bus, mem_wb_bus, mem_write_reg, wb_wb_bus, wb_write_reg,
               stall, flush_if_id, forward_a, forward_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  halt, id_valid, id_execute_bus, id_memory_bus, id_wb_bus,
               id_rs, id_rt, id_rd, branch_taken,
        output ex_execute_bus, ex_memory_bus, ex_wb_bus, ex_rs, ex_rt, ex_write_reg,
               mem_memory_bus, mem_wb_bus, mem_write_reg, wb_wb_bus, wb_write_reg,
               stall, flush_if_id, forward_a, forward_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe_sequencer.sv
// Carries decoded control through EX/MEM/WB, inserts load-use stalls and branch
// bubbles, drives ALU forwarding selects and saturating stall/flush counters.
module ctrl_pipe_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    ctrl_pipe_sequencer_if.slave  p
);
    typedef struct packed {
        logic [8:0] exec;
        logic [2:0] mem;
        logic [1:0] wb;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
    } ex_stage_t;

    ex_stage_t   ex_q, ex_d;
    logic [2:0]  mem_mem_q;
    logic [1:0]  mem_wb_q;
    logic [4:0]  mem_wr_q;
    logic [1:0]  wb_wb_q;
    logic [4:0]  wb_wr_q;
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        hazard, stall, flush;

    assign hazard = p.id_valid & ex_q.mem[1] & (ex_q.wr != 5'd0) &
                    ((ex_q.wr == p.id_rs) | (ex_q.wr == p.id_rt));
    assign stall  = hazard & ~p.branch_taken & ~p.halt;
    assign flush  = ~p.halt & (p.branch_taken |
                    (p.id_valid & ~stall & (p.id_execute_bus[5] | p.id_execute_bus[4])));

    // Stall, taken branch and invalid ID all collapse to the same all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (p.id_valid && !stall && !p.branch_taken) begin
            ex_d.exec = p.id_execute_bus;
            ex_d.mem  = p.id_memory_bus;
            ex_d.wb   = p.id_wb_bus;
            ex_d.rs   = p.id_rs;
            ex_d.rt   = p.id_rt;
            ex_d.wr   = p.id_execute_bus[8] ? p.id_rd : p.id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_mem_q   <= '0;
            mem_wb_q    <= '0;
            mem_wr_q    <= '0;
            wb_wb_q     <= '0;
            wb_wr_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!p.halt) begin
            ex_q      <= ex_d;
            mem_mem_q <= ex_q.mem;
            mem_wb_q  <= ex_q.wb;
            mem_wr_q  <= ex_q.wr;
            wb_wb_q   <= mem_wb_q;
            wb_wr_q   <= mem_wr_q;
            if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    // The younger producer (MEM) wins over WB; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_wb_q[1] && mem_wr_q != 5'd0 && mem_wr_q == src) return 2'b10;
        if (wb_wb_q[1]  && wb_wr_q  != 5'd0 && wb_wr_q  == src) return 2'b01;
        return 2'b00;
    endfunction

    assign p.forward_a      = fwd_sel(ex_q.rs);
    assign p.forward_b      = fwd_sel(ex_q.rt);
    assign p.stall          = stall;
    assign p.flush_if_id    = flush;
    assign p.ex_execute_bus = ex_q.exec;
    assign p.ex_memory_bus  = ex_q.mem;
    assign p.ex_wb_bus      = ex_q.wb;
    assign p.ex_rs          = ex_q.rs;
    assign p.ex_rt          = ex_q.rt;
    assign p.ex_write_reg   = ex_q.wr;
    assign p.mem_memory_bus = mem_mem_q;
    assign p.mem_wb_bus     = mem_wb_q;
    assign p.mem_write_reg  = mem_wr_q;
    assign p.wb_wb_bus      = wb_wb_q;
    assign p.wb_write_reg   = wb_wr_q;
    assign p.stall_cnt      = stall_cnt_q;
    assign p.flush_cnt      = flush_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_sequencer.sv
// Scoreboard bench: a whole-instruction pipeline model predicts every cycle's
// outputs; a negedge monitor pops and compares them.
module tb_ctrl_pipe_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_pipe_sequencer_if bus();
    ctrl_pipe_sequencer dut (.clk(clk), .reset(reset), .p(bus));

    typedef struct {
        logic [8:0] exec; logic [2:0] mem; logic [1:0] wb;
        logic [4:0] rs; logic [4:0] rt; logic [4:0] wr;
    } instr_t;

    typedef struct {
        logic [8:0] ex_exec; logic [2:0] ex_mem; logic [1:0] ex_wb;
        logic [4:0] ex_rs; logic [4:0] ex_rt; logic [4:0] ex_wr;
        logic [2:0] mem_mem; logic [1:0] mem_wb; logic [4:0] mem_wr;
        logic [1:0] wb_wb; logic [4:0] wb_wr;
        logic stall; logic flush; logic [1:0] fa; logic [1:0] fb;
        logic [15:0] sc; logic [15:0] fc;
    } exp_t;

    exp_t   expq[$];
    instr_t m_ex, m_mem, m_wb;
    int     m_sc, m_fc;
    int     checks = 0;
    int     errors = 0;

    function automatic instr_t bubble();
        instr_t b;
        b.exec = '0; b.mem = '0; b.wb = '0; b.rs = '0; b.rt = '0; b.wr = '0;
        return b;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (m_mem.wb[1] && m_mem.wr != 0 && m_mem.wr == src) return 2'b10;
        if (m_wb.wb[1]  && m_wb.wr  != 0 && m_wb.wr  == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, predict this cycle's outputs, advance the model.
    task automatic step(input bit rst, input bit hlt, input bit v,
                        input logic [8:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input bit bt);
        exp_t e;
        instr_t n;
        bit hz, st, fl;
        reset = rst; bus.halt = hlt; bus.id_valid = v; bus.id_execute_bus = ex;
        bus.id_memory_bus = mem; bus.id_wb_bus = wb; bus.id_rs = rs; bus.id_rt = rt;
        bus.id_rd = rd; bus.branch_taken = bt;
        hz = v && m_ex.mem[1] && m_ex.wr != 0 && (m_ex.wr == rs || m_ex.wr == rt);
        st = hz && !bt && !hlt;
        fl = !hlt && (bt || (v && !st && (ex[5] || ex[4])));
        e.ex_exec = m_ex.exec; e.ex_mem = m_ex.mem; e.ex_wb = m_ex.wb;
        e.ex_rs = m_ex.rs; e.ex_rt = m_ex.rt; e.ex_wr = m_ex.wr;
        e.mem_mem = m_mem.mem; e.mem_wb = m_mem.wb; e.mem_wr = m_mem.wr;
        e.wb_wb = m_wb.wb; e.wb_wr = m_wb.wr;
        e.stall = st; e.flush = fl; e.fa = exp_fwd(m_ex.rs); e.fb = exp_fwd(m_ex.rt);
        e.sc = 16'(m_sc); e.fc = 16'(m_fc);
        expq.push_back(e);
        if (rst) begin
            m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_sc = 0; m_fc = 0;
        end else if (!hlt) begin
            m_wb = m_mem; m_mem = m_ex;
            if (v && !st && !bt) begin
                n.exec = ex; n.mem = mem; n.wb = wb; n.rs = rs; n.rt = rt;
                n.wr = ex[8] ? rd : rt;
                m_ex = n;
            end else m_ex = bubble();
            if (st && m_sc < 65535) m_sc++;
            if (fl && m_fc < 65535) m_fc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic nop();
        step(0, 0, 0, '0, '0, '0, '0, '0, '0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0, '0, '0, '0, '0, '0, 0);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("ex_execute_bus", 32'(bus.ex_execute_bus), 32'(e.ex_exec));
            chk("ex_memory_bus",  32'(bus.ex_memory_bus),  32'(e.ex_mem));
            chk("ex_wb_bus",      32'(bus.ex_wb_bus),      32'(e.ex_wb));
            chk("ex_rs",          32'(bus.ex_rs),          32'(e.ex_rs));
            chk("ex_rt",          32'(bus.ex_rt),          32'(e.ex_rt));
            chk("ex_write_reg",   32'(bus.ex_write_reg),   32'(e.ex_wr));
            chk("mem_memory_bus", 32'(bus.mem_memory_bus), 32'(e.mem_mem));
            chk("mem_wb_bus",     32'(bus.mem_wb_bus),     32'(e.mem_wb));
            chk("mem_write_reg",  32'(bus.mem_write_reg),  32'(e.mem_wr));
            chk("wb_wb_bus",      32'(bus.wb_wb_bus),      32'(e.wb_wb));
            chk("wb_write_reg",   32'(bus.wb_write_reg),   32'(e.wb_wr));
            chk("stall",          32'(bus.stall),          32'(e.stall));
            chk("flush_if_id",    32'(bus.flush_if_id),    32'(e.flush));
            chk("forward_a",      32'(bus.forward_a),      32'(e.fa));
            chk("forward_b",      32'(bus.forward_b),      32'(e.fb));
            chk("stall_cnt",      32'(bus.stall_cnt),      32'(e.sc));
            chk("flush_cnt",      32'(bus.flush_cnt),      32'(e.fc));
        end
    end

    initial begin
        reset = 1'b1; bus.halt = 0; bus.id_valid = 0; bus.id_execute_bus = '0;
        bus.id_memory_bus = '0; bus.id_wb_bus = '0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_rd = '0; bus.branch_taken = 0;
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_sc = 0; m_fc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_write_reg", 32'(bus.ex_write_reg), 0);
        chk("reset stall_cnt", 32'(bus.stall_cnt), 0);
        chk("reset flush_cnt", 32'(bus.flush_cnt), 0);
        chk("reset stall", 32'(bus.stall), 0);

        // Straight line R-type rd = 3,4,5
        nop();
        for (int i = 3; i <= 5; i++) step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd1, 5'd2, 5'(i), 0);
        chk("line ex_write_reg", 32'(bus.ex_write_reg), 5);
        chk("line mem_write_reg", 32'(bus.mem_write_reg), 4);
        chk("line wb_write_reg", 32'(bus.wb_write_reg), 3);

        // Load-use on r8
        do_reset();
        step(0, 0, 1, 9'b001000000, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 0);
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd8, 5'd2, 5'd9, 0);
        chk("loaduse bubble exec", 32'(bus.ex_execute_bus), 0);
        chk("loaduse bubble wr", 32'(bus.ex_write_reg), 0);
        chk("loaduse mem_write_reg", 32'(bus.mem_write_reg), 8);
        chk("loaduse stall_cnt", 32'(bus.stall_cnt), 1);
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd8, 5'd2, 5'd9, 0);
        chk("loaduse forward_a", 32'(bus.forward_a), 32'b01);
        chk("loaduse stall_cnt hold", 32'(bus.stall_cnt), 1);
        nop();

        // Forwarding priority on r6, then r0 never forwards
        do_reset();
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd1, 5'd2, 5'd6, 0);
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd3, 5'd4, 5'd6, 0);
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd6, 5'd6, 5'd7, 0);
        chk("prio forward_a", 32'(bus.forward_a), 32'b10);
        chk("prio forward_b", 32'(bus.forward_b), 32'b10);
        do_reset();
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd1, 5'd2, 5'd0, 0);
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd1, 5'd2, 5'd0, 0);
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd0, 5'd0, 5'd7, 0);
        chk("r0 forward_a", 32'(bus.forward_a), 0);
        chk("r0 forward_b", 32'(bus.forward_b), 0);

        // Branch taken while a load-use hazard is pending
        do_reset();
        step(0, 0, 1, 9'b001000000, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 0);
        step(0, 0, 1, 9'h102, 3'b000, 2'b10, 5'd8, 5'd2, 5'd9, 1);
        chk("branch ex bubble", 32'(bus.ex_execute_bus), 0);
        chk("branch flush_cnt", 32'(bus.flush_cnt), 1);
        chk("branch stall_cnt", 32'(bus.stall_cnt), 0);

        // Jump in ID, then 4 halted cycles
        do_reset();
        step(0, 0, 1, 9'b000100000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 0);
        chk("jump in ex", 32'(bus.ex_execute_bus), 32'h020);
        chk("jump flush_cnt", 32'(bus.flush_cnt), 1);
        repeat (4) step(0, 1, 1, 9'($urandom), 3'($urandom), 2'($urandom),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 1);
        chk("halt ex frozen", 32'(bus.ex_execute_bus), 32'h020);
        chk("halt flush_cnt", 32'(bus.flush_cnt), 1);

        // Random traffic with small register range to provoke hazards
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 9'($urandom), 3'($urandom), 2'($urandom), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);

        // Flush counter saturation, then reset mid-sequence
        do_reset();
        for (int i = 0; i < 65540; i++) step(0, 0, 0, '0, '0, '0, '0, '0, '0, 1);
        chk("sat flush_cnt", 32'(bus.flush_cnt), 32'hFFFF);
        step(1, 1, 1, 9'h1FF, 3'b111, 2'b11, 5'd8, 5'd8, 5'd8, 1);
        chk("rst flush_cnt", 32'(bus.flush_cnt), 0);
        chk("rst stall_cnt", 32'(bus.stall_cnt), 0);
        chk("rst ex_execute_bus", 32'(bus.ex_execute_bus), 0);
        chk("rst mem_wb_bus", 32'(bus.mem_wb_bus), 0);
        nop();

        @(negedge clk); #1;
        chk("scoreboard drained", 32'(expq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
